// File: rtl/arb_grant_lock_mux.sv
// Grant-lock stage behind a combinational fixed-priority arbiter: captures a one-hot
// grant, holds it for a whole burst and muxes the owner's stream onto one output.
module arb_grant_lock_mux #(
    parameter int NumRequests = 4,
    parameter int DataWidth   = 32,
    parameter int MaxBurst    = 16,
    localparam int IdW        = (NumRequests > 1) ? $clog2(NumRequests) : 1,
    localparam int CntW       = $clog2(MaxBurst + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NumRequests-1:0]           req_valid,
    input  logic [NumRequests*DataWidth-1:0] req_data,
    input  logic [NumRequests-1:0]           req_last,
    output logic [NumRequests-1:0]           req_ready,
    output logic [NumRequests-1:0]           arb_request,
    input  logic [NumRequests-1:0]           arb_grant,
    output logic                             out_valid,
    output logic [DataWidth-1:0]             out_data,
    output logic                             out_last,
    input  logic                             out_ready,
    output logic [IdW-1:0]                   out_id,
    output logic                             busy,
    output logic                             err_grant,
    output logic                             err_burst
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_reg;
    logic [IdW-1:0]  owner_reg;
    logic [CntW-1:0] beat_cnt_reg;
    logic            err_grant_reg;
    logic            err_burst_reg;

    logic                 locked;
    logic                 grant_any;
    logic                 grant_onehot;
    logic                 grant_multi;
    logic [IdW-1:0]       grant_idx;
    logic                 owner_valid;
    logic                 owner_last;
    logic                 watchdog_last;
    logic                 beat;
    logic [DataWidth-1:0] req_data_arr [NumRequests];

    assign locked = (state_reg == LOCKED);

    // Clearing the lowest set bit leaves zero exactly when the vector is one-hot.
    assign grant_any    = |arb_grant;
    assign grant_onehot = grant_any && ((arb_grant & (arb_grant - NumRequests'(1))) == '0);
    assign grant_multi  = grant_any && !grant_onehot;

    // Index bit gi is the OR of every grant line whose position has bit gi set;
    // only meaningful when the grant is one-hot, which is the only time it is used.
    for (genvar gi = 0; gi < IdW; gi++) begin : g_grant_idx
        logic [NumRequests-1:0] sel_mask;
        always_comb begin
            sel_mask = '0;
            for (int i = 0; i < NumRequests; i++) begin
                sel_mask[i] = 1'((i >> gi) & 1);
            end
        end
        assign grant_idx[gi] = |(arb_grant & sel_mask);
    end

    for (genvar gi = 0; gi < NumRequests; gi++) begin : g_req
        assign req_data_arr[gi] = req_data[gi*DataWidth +: DataWidth];
        assign req_ready[gi]    = locked && (owner_reg == IdW'(gi)) && out_ready;
    end

    assign owner_valid   = req_valid[owner_reg];
    assign owner_last    = req_last[owner_reg];
    assign watchdog_last = (beat_cnt_reg == CntW'(MaxBurst - 1));

    // The arbiter sees nothing while a burst is in flight.
    assign arb_request = locked ? '0 : req_valid;

    assign out_valid = locked && owner_valid;
    assign out_data  = locked ? req_data_arr[owner_reg] : '0;
    assign out_last  = locked && (owner_last || watchdog_last);
    assign out_id    = locked ? owner_reg : '0;
    assign busy      = locked;
    assign err_grant = err_grant_reg;
    assign err_burst = err_burst_reg;

    assign beat = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            beat_cnt_reg  <= '0;
            err_grant_reg <= 1'b0;
            err_burst_reg <= 1'b0;
        end else begin
            err_grant_reg <= 1'b0;
            err_burst_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_onehot) begin
                        owner_reg    <= grant_idx;
                        beat_cnt_reg <= '0;
                        state_reg    <= LOCKED;
                    end else if (grant_multi) begin
                        err_grant_reg <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (beat) begin
                        if (out_last) begin
                            state_reg     <= IDLE;
                            beat_cnt_reg  <= '0;
                            // Release forced by the beat limit rather than the requester.
                            err_burst_reg <= !owner_last;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + CntW'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
